// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared types and constants for the SPI slave frame sequencer.
//   seq_state_e  frame state (IDLE, CMD, WR_DATA, RD_DATA)
//   CMD_RW_BIT   R/W flag position in the command byte at the default width
//   CMD_READ     value of the R/W flag that selects a read frame
//   ADDR_INC     1 when `SPI_SEQ_ADDR_INC_EN is defined (burst addressing),
//                0 otherwise (address held for the whole frame)
package spi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WR_DATA = 2'd2,
    RD_DATA = 2'd3
  } seq_state_e;

  localparam int   SEQ_DATA_W = 8;
  localparam int   CMD_RW_BIT = SEQ_DATA_W - 1;
  localparam logic CMD_READ   = 1'b1;

`ifdef SPI_SEQ_ADDR_INC_EN
  localparam logic ADDR_INC = 1'b1;
`else
  localparam logic ADDR_INC = 1'b0;
`endif

endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: SYNC_STAGES-deep synchronizers for the SPI pins plus
// single-clk edge strobes.
//   clk, rst_n        system clock, synchronous active-low reset
//   sclk, cs_n, mosi  raw asynchronous SPI pins
//   mosi_s            synchronized MOSI, aligned with sclk_rise
//   sclk_rise/fall    one-clk strobes on synchronized SCLK edges
//   cs_rise/fall      one-clk strobes on synchronized CS_N edges
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall
);

  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0] pin;
  logic [NUM_LANES-1:0] lvl;
  logic [1:0]           prev;

  assign pin = {mosi, cs_n, sclk};

  // All lanes reset to 0, including CS_N: if reset is released while CS_N
  // is already low no cs_fall appears, so a half-seen frame is ignored.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [SYNC_STAGES-1:0] ff;
    always_ff @(posedge clk) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[SYNC_STAGES-2:0], pin[l]};
    end
    assign lvl[l] = ff[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= '0;
    else        prev <= lvl[1:0];
  end

  assign mosi_s    = lvl[2];
  assign sclk_rise =  lvl[0] & ~prev[0];
  assign sclk_fall = ~lvl[0] &  prev[0];
  assign cs_rise   =  lvl[1] & ~prev[1];
  assign cs_fall   = ~lvl[1] &  prev[1];

endmodule

// File: rtl/spi_slave_seq.sv
// spi_slave_seq: SPI mode-0 slave frame sequencer. The first byte of a frame
// is a command (R/W flag + address); each following byte becomes one write
// strobe or one read fetch toward the register file.
//   clk, rst_n          system clock, synchronous active-low reset
//   spi_sclk/cs_n/mosi  SPI pins (asynchronous), spi_miso slave data out
//   reg_addr/wdata      register address / write data, valid with strobes
//   reg_wr, reg_rd      one-clk write / read strobes
//   reg_rdata           read data, valid 1 clk after reg_rd
//   busy                frame active; frame_err one-clk truncated-byte pulse
// Build option: `SPI_SEQ_ADDR_INC_EN selects address auto-increment per data
// byte; when undefined the command address is held for the whole frame.
module spi_slave_seq
  import spi_seq_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam int CW = $clog2(DATA_W);

  logic mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (spi_sclk),
    .cs_n      (spi_cs_n),
    .mosi      (spi_mosi),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall)
  );

  seq_state_e        state, state_nxt;
  logic [CW-1:0]     bitcnt;
  logic              byte_done;
  logic [DATA_W-1:0] rx, tx;
  logic              rdata_vld, inc_pend;
  logic              wr_nxt, rd_nxt, err_nxt, ld_addr, step_addr;
  logic              active;

  assign active = (state != IDLE);
  assign busy   = active;

  // Bit counter and RX shifter; SPI activity outside a frame is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bitcnt    <= '0;
      byte_done <= 1'b0;
      rx        <= '0;
    end else begin
      byte_done <= 1'b0;
      if (cs_fall) begin
        bitcnt <= '0;
      end else if (sclk_rise && active) begin
        rx <= {rx[DATA_W-2:0], mosi_s};
        if (bitcnt == CW'(DATA_W-1)) begin
          bitcnt    <= '0;
          byte_done <= 1'b1;
        end else begin
          bitcnt <= bitcnt + 1'b1;
        end
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state. cs_rise is applied last so a byte completing in the
  // same clk is still decoded by the output process before going idle.
  always_comb begin
    state_nxt = state;
    if (cs_fall) begin
      state_nxt = CMD;
    end else if (state == CMD && byte_done) begin
      state_nxt = (rx[DATA_W-1] == CMD_READ) ? RD_DATA : WR_DATA;
    end
    if (cs_rise) state_nxt = IDLE;
  end

  // FSM: strobe requests, registered below
  always_comb begin
    wr_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    err_nxt   = 1'b0;
    ld_addr   = 1'b0;
    step_addr = 1'b0;
    if (byte_done) begin
      case (state)
        CMD: begin
          ld_addr = 1'b1;
          rd_nxt  = (rx[DATA_W-1] == CMD_READ);
        end
        WR_DATA: wr_nxt = 1'b1;
        RD_DATA: begin
          rd_nxt    = 1'b1;
          step_addr = ADDR_INC;
        end
        default: ;
      endcase
    end
    // bitcnt is already 0 when byte_done coincides with cs_rise
    if (cs_rise && active && bitcnt != '0) err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      rdata_vld <= 1'b0;
      inc_pend  <= 1'b0;
      tx        <= '0;
    end else begin
      reg_wr    <= wr_nxt;
      reg_rd    <= rd_nxt;
      frame_err <= err_nxt;
      rdata_vld <= reg_rd;
      // writes step the address one clk after the strobe so reg_addr stays
      // valid with reg_wr; read prefetch steps it together with reg_rd
      inc_pend  <= wr_nxt & ADDR_INC;
      if (wr_nxt) reg_wdata <= rx;
      if (ld_addr)                    reg_addr <= rx[ADDR_W-1:0];
      else if (step_addr || inc_pend) reg_addr <= reg_addr + 1'b1;
      // TX: load wins over shift; the fall right after a byte boundary
      // (bitcnt == 0) must not disturb the freshly loaded MSB
      if (cs_fall)
        tx <= '0;
      else if (rdata_vld && state == RD_DATA)
        tx <= reg_rdata;
      else if (sclk_fall && state == RD_DATA && bitcnt != '0)
        tx <= {tx[DATA_W-2:0], 1'b0};
    end
  end

  assign spi_miso = (state == RD_DATA) & tx[DATA_W-1];

endmodule

// File: tb/tb_spi_slave_seq.sv
module tb_spi_slave_seq;

  localparam int DATA_W = 8, ADDR_W = 7, SYNC_STAGES = 2, HP = 6;
`ifdef SPI_SEQ_ADDR_INC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic reg_wr, reg_rd, busy, frame_err;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata, reg_rdata;

  int checks = 0, errors = 0, cyc = 0;
  logic [6:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [6:0] rd_addr_q[$];
  int wr_cyc_q[$], rise_q[$];
  int err_hi = 0, err_rise = 0, viol = 0, last_rise = 0;
  logic prev_err = 1'b0, prev_strobe = 1'b0;
  logic [7:0] fb[8], mb[8], junk;

  spi_slave_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file responder and strobe monitor (sampled mid-cycle).
  initial begin
    reg_rdata = '0;
    forever begin
      @(negedge clk);
      if (reg_wr === 1'b1) begin
        wr_addr_q.push_back(reg_addr);
        wr_data_q.push_back(reg_wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (reg_rd === 1'b1) begin
        rd_addr_q.push_back(reg_addr);
        reg_rdata = 8'({1'b0, reg_addr} + 8'h10);
      end
      if (frame_err === 1'b1) begin
        err_hi++;
        if (prev_err !== 1'b1) err_rise++;
      end
      if ((reg_wr === 1'b1 && reg_rd === 1'b1) ||
          ((reg_wr === 1'b1 || reg_rd === 1'b1) && prev_strobe)) viol++;
      prev_err    = frame_err;
      prev_strobe = (reg_wr === 1'b1) || (reg_rd === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int hi, input int lo, output logic [7:0] rb);
    rb = '0;
    for (int i = hi; i >= lo; i--) begin
      spi_mosi = b[i];
      repeat (HP) @(negedge clk);
      spi_sclk = 1'b1; last_rise = cyc; rb[i] = spi_miso;
      repeat (HP) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HP) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * HP) @(negedge clk);
  endtask

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    wr_cyc_q.delete(); rise_q.delete();
    err_hi = 0; err_rise = 0;
  endtask

  task automatic do_frame(input int n);
    clear_mon();
    cs_low();
    chk("busy_in_frame", busy, 1);
    for (int k = 0; k < n; k++) begin
      spi_bits(fb[k], 7, 0, mb[k]);
      rise_q.push_back(last_rise);
    end
    cs_high();
  endtask

  // Expected traffic from the command byte: address for access k is
  // cmd_addr + k (mod 128) in burst mode, cmd_addr otherwise.
  task automatic check_frame(input int n);
    logic [6:0] a, ak;
    a = fb[0][6:0];
    if (fb[0][7]) begin
      chk("rd_count", rd_addr_q.size(), n);
      chk("wr_count_in_read", wr_addr_q.size(), 0);
      for (int k = 0; k < n && k < rd_addr_q.size(); k++) begin
        ak = 7'(a + k * INC);
        chk("rd_addr", rd_addr_q[k], ak);
        if (k < n - 1) chk("miso_byte", mb[k+1], 8'({1'b0, ak} + 8'h10));
      end
    end else begin
      chk("wr_count", wr_addr_q.size(), n - 1);
      chk("rd_count_in_write", rd_addr_q.size(), 0);
      for (int k = 0; k < n - 1 && k < wr_addr_q.size(); k++) begin
        ak = 7'(a + k * INC);
        chk("wr_addr", wr_addr_q[k], ak);
        chk("wr_data", wr_data_q[k], fb[k+1]);
        chk("wr_latency", wr_cyc_q[k] - rise_q[k+1], SYNC_STAGES + 2);
      end
    end
    chk("frame_err_none", err_hi, 0);
    chk("busy_after", busy, 0);
    chk("miso_idle", spi_miso, 0);
  endtask

  initial begin
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr", reg_wr, 0);
    chk("rst_rd", reg_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_miso", spi_miso, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);

    // write burst
    fb[0] = 8'h05; fb[1] = 8'hA5; fb[2] = 8'h3C;
    do_frame(3); check_frame(3);

    // read burst
    fb[0] = 8'h8A; fb[1] = 8'h00; fb[2] = 8'h00;
    do_frame(3); check_frame(3);

    // address wrap
    fb[0] = 8'h7F; fb[1] = 8'h11; fb[2] = 8'h22;
    do_frame(3); check_frame(3);

    // truncated byte
    clear_mon();
    cs_low();
    spi_bits(8'h03, 7, 0, junk);
    spi_bits(8'hFF, 7, 5, junk);
    cs_high();
    chk("trunc_wr_count", wr_addr_q.size(), 0);
    chk("trunc_err_pulses", err_rise, 1);
    chk("trunc_err_width", err_hi, 1);
    chk("trunc_busy", busy, 0);

    // reset mid-frame during the second data byte
    clear_mon();
    cs_low();
    spi_bits(8'h05, 7, 0, junk);
    spi_bits(8'hA5, 7, 0, junk);
    spi_bits(8'h3C, 7, 5, junk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (4) @(negedge clk);
    chk("rstmid_busy", busy, 0);
    spi_bits(8'h3C, 4, 0, junk);
    spi_bits(8'h77, 7, 0, junk);
    cs_high();
    chk("rstmid_wr_count", wr_addr_q.size(), 0);
    chk("rstmid_rd_count", rd_addr_q.size(), 0);
    chk("rstmid_err", err_hi, 0);
    fb[0] = 8'h01; fb[1] = 8'h55;
    do_frame(2); check_frame(2);

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      int n;
      n = int'($urandom_range(2, 4));
      for (int k = 0; k < n; k++) fb[k] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) fb[0][6:0] = 7'h7E;
      do_frame(n); check_frame(n);
    end

    chk("strobe_spacing", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
